// File: rtl/arm_ctrl_pipe_if.sv
// Decode-side bus for arm_ctrl_pipe: instruction fields, pipeline control
// and the registered control word leaving the last stage.
interface arm_ctrl_pipe_if;
  logic       in_valid;
  logic [3:0] cond;
  logic [3:0] opcode;
  logic [1:0] mode;
  logic       s_in;
  logic [3:0] status;
  logic       stall;
  logic       flush;
  logic       out_valid;
  logic [9:0] out_ctrl;
  logic       out_illegal;

  modport master (
    output in_valid, cond, opcode, mode, s_in, status, stall, flush,
    input  out_valid, out_ctrl, out_illegal
  );

  modport slave (
    input  in_valid, cond, opcode, mode, s_in, status, stall, flush,
    output out_valid, out_ctrl, out_illegal
  );
endinterface

// File: rtl/arm_ctrl_pipe.sv
// arm_ctrl_pipe: pipelined ID-stage control decoder.
// Decodes mode/opcode/S into {S,B,EXE_CMD,MEM_W,MEM_R,WB}, carries it through
// STAGES registers with stall/flush, and squashes BR_SHADOW cycles after a
// taken branch. out_ctrl[9] is reserved and always zero; the word occupies [8:0].
// Optional feature: define ARM_CTRL_COND_EN to evaluate the ARM condition
// field against status; otherwise every instruction is treated as AL.
module arm_ctrl_pipe #(
  parameter int STAGES    = 2,
  parameter int BR_SHADOW = 1
) (
  input  logic           clk,
  input  logic           rst,
  arm_ctrl_pipe_if.slave bus
);

  localparam logic [3:0] SHADOW_LD = 4'(BR_SHADOW);

  // opcodes in ALU mode
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  logic       d_s, d_b, d_mw, d_mr, d_wb, d_ill;
  logic [3:0] d_exe;
  logic [9:0] d_word;
  logic       cond_pass;

  logic [3:0] shadow_cnt;
  logic       shadow_busy;

  // stage 0 is the combinational input entry, stages 1..STAGES are registers
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0]        ill_pipe;
  logic [STAGES:0][9:0]   ctrl_pipe;
  logic [STAGES-1:0]      vld_q;
  logic [STAGES-1:0]      ill_q;
  logic [STAGES-1:0][9:0] ctrl_q;

  logic       vld_in, ill_in, pass_in;
  logic [9:0] ctrl_in;

  // mode/opcode decode into the raw control word
  always_comb begin
    d_s   = 1'b0;
    d_b   = 1'b0;
    d_exe = 4'b0000;
    d_mw  = 1'b0;
    d_mr  = 1'b0;
    d_wb  = 1'b0;
    d_ill = 1'b0;
    case (bus.mode)
      2'b00: begin
        d_s  = bus.s_in;
        d_wb = 1'b1;
        case (bus.opcode)
          OP_MOV: d_exe = 4'b0001;
          OP_MVN: d_exe = 4'b1001;
          OP_ADD: d_exe = 4'b0010;
          OP_ADC: d_exe = 4'b0011;
          OP_SUB: d_exe = 4'b0100;
          OP_SBC: d_exe = 4'b0101;
          OP_AND: d_exe = 4'b0110;
          OP_ORR: d_exe = 4'b0111;
          OP_EOR: d_exe = 4'b1000;
          OP_CMP: begin d_exe = 4'b0100; d_wb = 1'b0; d_s = 1'b1; end
          OP_TST: begin d_exe = 4'b0110; d_wb = 1'b0; d_s = 1'b1; end
          default: begin d_s = 1'b0; d_wb = 1'b0; d_ill = 1'b1; end
        endcase
      end
      2'b01: begin
        // s_in is the L bit: load writes back, store writes memory
        d_exe = 4'b0010;
        d_mr  = bus.s_in;
        d_wb  = bus.s_in;
        d_mw  = ~bus.s_in;
      end
      2'b10:   d_b   = 1'b1;
      default: d_ill = 1'b1;
    endcase
    d_word = {1'b0, d_s, d_b, d_exe, d_mw, d_mr, d_wb};
  end

`ifdef ARM_CTRL_COND_EN
  // ARM condition evaluation on {N,Z,C,V}; 1111 never passes
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = bus.status;
    case (bus.cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  logic unused_cond_in;
  assign unused_cond_in = ^{bus.cond, bus.status};
  assign cond_pass      = 1'b1;
`endif

  // entry formation: shadowed inputs become bubbles, failed conditions become nops
  assign shadow_busy = (shadow_cnt != 4'd0);
  assign vld_in      = bus.in_valid & ~shadow_busy;
  assign pass_in     = vld_in & cond_pass;
  assign ctrl_in     = pass_in ? d_word : 10'd0;
  assign ill_in      = pass_in & d_ill;

  assign vld_pipe  = {vld_q, vld_in};
  assign ill_pipe  = {ill_q, ill_in};
  assign ctrl_pipe = {ctrl_q, ctrl_in};

  // branch shadow counter: loads on a taken branch, counts down while unstalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shadow_cnt <= 4'd0;
    else if (bus.flush)
      shadow_cnt <= 4'd0;
    else if (!bus.stall) begin
      if (shadow_busy)
        shadow_cnt <= shadow_cnt - 4'd1;
      else if (pass_in && d_b)
        shadow_cnt <= SHADOW_LD;
    end
  end

  // register pipeline: shift one entry per unstalled cycle, flush clears all
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      ill_q  <= '0;
      ctrl_q <= '0;
    end else if (bus.flush) begin
      vld_q  <= '0;
      ill_q  <= '0;
      ctrl_q <= '0;
    end else if (!bus.stall) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i]  <= vld_pipe[i];
        ill_q[i]  <= ill_pipe[i];
        ctrl_q[i] <= ctrl_pipe[i];
      end
    end
  end

  assign bus.out_valid   = vld_pipe[STAGES];
  assign bus.out_illegal = ill_pipe[STAGES];
  assign bus.out_ctrl    = ctrl_pipe[STAGES];

endmodule

// File: tb/tb_arm_ctrl_pipe.sv
// Directed bench for arm_ctrl_pipe with STAGES=2, BR_SHADOW=2.
module tb_arm_ctrl_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_tot  = 0;

  arm_ctrl_pipe_if bus ();

  arm_ctrl_pipe #(.STAGES(2), .BR_SHADOW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] W_ADD_S = 10'b0_1_0_0010_001;
  localparam logic [9:0] W_LDR   = 10'b0_0_0_0010_011;
  localparam logic [9:0] W_STR   = 10'b0_0_0_0010_100;
  localparam logic [9:0] W_B     = 10'b0_0_1_0000_000;
  localparam logic [9:0] W_ORR   = 10'b0_0_0_0111_001;
  localparam logic [9:0] W_SUB   = 10'b0_0_0_0100_001;
  localparam logic [9:0] W_MVN   = 10'b0_0_0_1001_001;
  localparam logic [9:0] W_CMP   = 10'b0_1_0_0100_000;
  localparam logic [9:0] W_TST   = 10'b0_1_0_0110_000;
  localparam logic [9:0] W_MOV_S = 10'b0_1_0_0001_001;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] op, input logic [1:0] m, input logic s);
    bus.in_valid = 1'b1;
    bus.cond     = c;
    bus.opcode   = op;
    bus.mode     = m;
    bus.s_in     = s;
  endtask

  task automatic idle;
    bus.in_valid = 1'b0;
    bus.cond     = 4'b1110;
    bus.opcode   = 4'b0000;
    bus.mode     = 2'b00;
    bus.s_in     = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.status = 4'b0000;
    drive(4'b1110, 4'b0100, 2'b00, 1'b1);
    tick; tick;
    n_tot++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_tot++; if (bus.out_ctrl !== 10'd0) $display("FAIL reset_ctrl: got %b expected 0", bus.out_ctrl); else n_pass++;
    n_tot++; if (bus.out_illegal !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", bus.out_illegal); else n_pass++;
    idle;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_alu;
    drive(4'b1110, 4'b0100, 2'b00, 1'b1);   // ADD S
    tick;
    n_tot++; if (bus.out_valid !== 1'b0) $display("FAIL add_latency: valid got %b expected 0 after 1 edge", bus.out_valid); else n_pass++;
    drive(4'b1110, 4'b1111, 2'b00, 1'b0);   // MVN
    tick;
    n_tot++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== W_ADD_S) $display("FAIL add: got v=%b %b expected v=1 %b", bus.out_valid, bus.out_ctrl, W_ADD_S); else n_pass++;
    drive(4'b1110, 4'b1010, 2'b00, 1'b0);   // CMP forces S
    tick;
    n_tot++; if (bus.out_ctrl !== W_MVN) $display("FAIL mvn: got %b expected %b", bus.out_ctrl, W_MVN); else n_pass++;
    drive(4'b1110, 4'b1000, 2'b00, 1'b0);   // TST
    tick;
    n_tot++; if (bus.out_ctrl !== W_CMP) $display("FAIL cmp: got %b expected %b", bus.out_ctrl, W_CMP); else n_pass++;
    idle;
    tick;
    n_tot++; if (bus.out_ctrl !== W_TST || bus.out_valid !== 1'b1) $display("FAIL tst: got v=%b %b expected v=1 %b", bus.out_valid, bus.out_ctrl, W_TST); else n_pass++;
    tick;
    n_tot++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 10'd0) $display("FAIL bubble: got v=%b %b expected v=0 0", bus.out_valid, bus.out_ctrl); else n_pass++;
  endtask

  task automatic test_back_to_back;
    drive(4'b1110, 4'b0000, 2'b01, 1'b1);   // LDR
    tick;
    drive(4'b1110, 4'b0000, 2'b01, 1'b0);   // STR
    tick;
    n_tot++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== W_LDR) $display("FAIL ldr: got v=%b %b expected v=1 %b", bus.out_valid, bus.out_ctrl, W_LDR); else n_pass++;
    idle;
    tick;
    n_tot++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== W_STR) $display("FAIL str: got v=%b %b expected v=1 %b", bus.out_valid, bus.out_ctrl, W_STR); else n_pass++;
    tick;
  endtask

  task automatic test_shadow;
    drive(4'b1110, 4'b0000, 2'b10, 1'b0);   // B
    tick;
    drive(4'b1110, 4'b1101, 2'b00, 1'b0);   // MOV (squashed)
    tick;
    n_tot++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== W_B) $display("FAIL branch: got v=%b %b expected v=1 %b", bus.out_valid, bus.out_ctrl, W_B); else n_pass++;
    drive(4'b1110, 4'b0001, 2'b00, 1'b0);   // EOR (squashed)
    tick;
    n_tot++; if (bus.out_valid !== 1'b0) $display("FAIL shadow_mov: valid got %b expected 0", bus.out_valid); else n_pass++;
    drive(4'b1110, 4'b1100, 2'b00, 1'b0);   // ORR
    tick;
    n_tot++; if (bus.out_valid !== 1'b0) $display("FAIL shadow_eor: valid got %b expected 0", bus.out_valid); else n_pass++;
    idle;
    tick;
    n_tot++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== W_ORR) $display("FAIL orr_after_shadow: got v=%b %b expected v=1 %b", bus.out_valid, bus.out_ctrl, W_ORR); else n_pass++;
    tick;
  endtask

  task automatic test_flush_branch;
    // branch at the input together with flush: dropped, counter not loaded
    drive(4'b1110, 4'b0000, 2'b10, 1'b0);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    drive(4'b1110, 4'b1101, 2'b00, 1'b1);   // MOV S must not be squashed
    tick;
    n_tot++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 10'd0) $display("FAIL flush_branch_drop: got v=%b %b expected v=0 0", bus.out_valid, bus.out_ctrl); else n_pass++;
    idle;
    tick;
    n_tot++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== W_MOV_S) $display("FAIL flush_branch_mov: got v=%b %b expected v=1 %b", bus.out_valid, bus.out_ctrl, W_MOV_S); else n_pass++;
    tick;
  endtask

  task automatic test_cond;
    logic [9:0] exp_fail;
`ifdef ARM_CTRL_COND_EN
    exp_fail = 10'd0;
`else
    exp_fail = W_SUB;
`endif
    bus.status = 4'b0000;                   // Z=0
    drive(4'b0000, 4'b0010, 2'b00, 1'b0);   // SUBEQ
    tick;
    bus.status = 4'b0100;                   // Z=1
    drive(4'b0000, 4'b0010, 2'b00, 1'b0);
    tick;
    n_tot++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== exp_fail) $display("FAIL cond_eq_z0: got v=%b %b expected v=1 %b", bus.out_valid, bus.out_ctrl, exp_fail); else n_pass++;
    idle;
    bus.status = 4'b0000;
    tick;
    n_tot++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== W_SUB) $display("FAIL cond_eq_z1: got v=%b %b expected v=1 %b", bus.out_valid, bus.out_ctrl, W_SUB); else n_pass++;
    tick;
  endtask

  task automatic test_stall_flush;
    drive(4'b1110, 4'b0100, 2'b00, 1'b1);   // ADD S
    tick;
    drive(4'b1110, 4'b0010, 2'b00, 1'b0);   // SUB
    tick;
    n_tot++; if (bus.out_ctrl !== W_ADD_S) $display("FAIL pre_stall: got %b expected %b", bus.out_ctrl, W_ADD_S); else n_pass++;
    drive(4'b1110, 4'b1101, 2'b00, 1'b1);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_tot++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== W_ADD_S) $display("FAIL stall_hold%0d: got v=%b %b expected v=1 %b", k, bus.out_valid, bus.out_ctrl, W_ADD_S); else n_pass++;
    end
    bus.flush = 1'b1;
    tick;
    n_tot++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 10'd0 || bus.out_illegal !== 1'b0) $display("FAIL flush_stall: got v=%b %b i=%b expected all 0", bus.out_valid, bus.out_ctrl, bus.out_illegal); else n_pass++;
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    idle;
    tick;
    n_tot++; if (bus.out_valid !== 1'b0) $display("FAIL flush_stage1: valid got %b expected 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_illegal;
    drive(4'b1110, 4'b0100, 2'b11, 1'b1);   // mode 11
    tick;
    drive(4'b1110, 4'b0011, 2'b00, 1'b1);   // unlisted ALU opcode
    tick;
    n_tot++; if (bus.out_illegal !== 1'b1 || bus.out_ctrl !== 10'd0 || bus.out_valid !== 1'b1) $display("FAIL mode11: got v=%b %b i=%b expected v=1 0 i=1", bus.out_valid, bus.out_ctrl, bus.out_illegal); else n_pass++;
    idle;
    tick;
    n_tot++; if (bus.out_illegal !== 1'b1 || bus.out_ctrl !== 10'd0) $display("FAIL bad_opcode: got %b i=%b expected 0 i=1", bus.out_ctrl, bus.out_illegal); else n_pass++;
    tick;
    n_tot++; if (bus.out_illegal !== 1'b0) $display("FAIL illegal_clear: got %b expected 0", bus.out_illegal); else n_pass++;
  endtask

  task automatic test_reset_mid;
    drive(4'b1110, 4'b0100, 2'b00, 1'b1);
    tick;
    idle;
    tick;
    n_tot++; if (bus.out_ctrl !== W_ADD_S) $display("FAIL pre_reset: got %b expected %b", bus.out_ctrl, W_ADD_S); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_tot++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 10'd0) $display("FAIL async_reset: got v=%b %b expected v=0 0", bus.out_valid, bus.out_ctrl); else n_pass++;
    tick;
    rst = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_back_to_back;
    test_shadow;
    test_flush_branch;
    test_cond;
    test_stall_flush;
    test_illegal;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
